projectile_launch_ctrl: RTL
===========================

# projectile_launch_ctrl

Parametrised projectile-launch controller that generalises the per-character fireball controller. It arbitrates NUM_SLOTS projectile slots, requires the fire key to be released before each shot, enforces a frame-based cooldown between shots, and can allocate slots by fixed priority or round-robin. It sits between the keyboard decode (keycode/press) and the per-slot projectile sprite modules. All decisions are sampled on frame_clk_edge.

## Interface
- NUM_SLOTS, 5, number of projectile slots (1..16)
- FIRE_KEY, 8'h59, keycode that triggers a launch
- COOLDOWN_FRAMES, 8, frames after a launch during which no launch is accepted; 0 disables cooldown
- CNT_W, 4, cooldown counter width; must hold COOLDOWN_FRAMES
- ROUND_ROBIN, 0, 0 = lowest ready index wins; 1 = round-robin from pointer
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- frame_clk_edge  input  1  one-Clk-cycle strobe per video frame
- keycode  input  8  current key code
- press  input  1  1 = keycode is pressed, 0 = released
- dead_char  input  1  owning character is dead; blocks launches
- slot_ready  input  NUM_SLOTS  bit i = slot i is idle and may be launched
- fire  output  NUM_SLOTS  one-hot launch pulse, one Clk cycle wide
- cooldown_busy  output  1  cooldown counter nonzero
- shot_count  output  8  total launches since reset, wraps 255->0

## Operation
- Arming FSM, 2 states, transitions only on cycles with frame_clk_edge=1:
  - WAIT_RELEASE (reset state): goes to ARMED when keycode==FIRE_KEY and press=0.
  - ARMED: launches when keycode==FIRE_KEY, press=1, dead_char=0, cooldown==0, and |slot_ready. On launch, goes to WAIT_RELEASE.
  - dead_char=1 in ARMED forces WAIT_RELEASE with no launch.
- Slot select:
  - ROUND_ROBIN=0: lowest set index of slot_ready.
  - ROUND_ROBIN=1: first set bit at or after rr_ptr, searching upward with wrap. On launch, rr_ptr <= (granted+1) mod NUM_SLOTS. rr_ptr resets to 0.
- Blocked launches: a launch condition with no ready slot, or with cooldown nonzero, produces no fire and no state change. The FSM stays ARMED, so holding the key fires once a slot frees or the cooldown expires.
- Cooldown counter:
  - Loads COOLDOWN_FRAMES on the launch frame.
  - Otherwise decrements by 1 on each frame edge while nonzero, saturating at 0.
  - Not cleared by dead_char.
- shot_count increments by 1 on each launch.

## Timing
- Reset values: fire=0, cooldown_busy=0, shot_count=0, FSM=WAIT_RELEASE, cooldown=0, rr_ptr=0. Reset is asynchronous and takes effect mid-frame. Any pending pulse is dropped.
- Launch decision uses inputs sampled on the Clk edge where frame_clk_edge=1. The fire bit rises on that same edge (registered) and clears on the next Clk edge: exactly 1 cycle high, with at most one bit set.
- Inputs are ignored on cycles with frame_clk_edge=0. fire is still cleared on those cycles.
- Release and press in consecutive frames: release frame arms, press frame launches, giving minimum 2 frames per shot.
- cooldown_busy is registered and reflects the counter value. Next launch is possible COOLDOWN_FRAMES+1 frames after the previous launch frame, given the key was released and pressed in between.
- slot_ready changing between frame edges has no effect. Only the value at the frame edge counts.

## Test plan
- Reset, then FIRE_KEY release at frame 1 and press at frame 2, slot_ready=5'b11111, ROUND_ROBIN=0 -> fire=5'b00001 for 1 Clk after frame 2; shot_count=1; cooldown_busy=1.
- Hold press for 20 frames after a launch without release -> no further fire; FSM stays WAIT_RELEASE.
- COOLDOWN_FRAMES=8: launch at frame 2, release at frame 3, press from frame 4 onward -> next fire at frame 11; cooldown_busy low from frame 10.
- ROUND_ROBIN=1, all slots ready, 7 release/press shots with cooldown expired -> fire sequence slot 0,1,2,3,4,0,1. With slot_ready=5'b00101 after the slot-0 grant -> next grant is slot 2.
- ARMED with slot_ready=0 and key held: no fire. Raise slot_ready[3] at frame n -> fire[3] at frame n. dead_char=1 while ARMED -> no fire, and a fresh release is then required.
- Assert Reset asynchronously in the cycle fire is high -> fire drops immediately; shot_count=0, cooldown_busy=0.

Source files
------------

// File: rtl/projectile_launch_ctrl.sv
// Projectile launch controller: release-to-arm fire key, frame-based cooldown and
// fixed-priority or round-robin allocation across NUM_SLOTS projectile slots.
module projectile_launch_ctrl #(
  parameter int unsigned NUM_SLOTS       = 5,
  parameter logic [7:0]  FIRE_KEY        = 8'h59,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned CNT_W           = 4,
  parameter bit          ROUND_ROBIN     = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk_edge,
  input  logic [7:0]           keycode,
  input  logic                 press,
  input  logic                 dead_char,
  input  logic [NUM_SLOTS-1:0] slot_ready,
  output logic [NUM_SLOTS-1:0] fire,
  output logic                 cooldown_busy,
  output logic [7:0]           shot_count
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [0:0] {StWaitRelease, StArmed} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOTS-1:0] fire_q, fire_d;
  logic                 busy_q;
  logic [7:0]           shot_q, shot_d;

  logic [NUM_SLOTS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 found;
  int unsigned          idx;
  logic [PTR_W-1:0]     idx_w;
  logic                 key_match;

  // Slot search: offset k from the start point, wrapping when round-robin.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      idx   = ROUND_ROBIN ? ((32'(rr_ptr_q) + k) % NUM_SLOTS) : k;
      idx_w = PTR_W'(idx);
      if (!found && slot_ready[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

  assign key_match = (keycode == FIRE_KEY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    fire_d   = '0;
    shot_d   = shot_q;
    if (frame_clk_edge) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      case (state_q)
        StWaitRelease: begin
          if (key_match && !press) begin
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (dead_char) begin
            state_d = StWaitRelease;
          end else if (key_match && press && (cnt_q == '0) && found) begin
            state_d = StWaitRelease;
            fire_d  = grant;
            cnt_d   = CNT_W'(COOLDOWN_FRAMES);
            shot_d  = shot_q + 8'd1;
            if (ROUND_ROBIN) begin
              rr_ptr_d = (grant_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
          end
          // Blocked launches (no slot or cooling down) keep the FSM armed.
        end
        default: state_d = StWaitRelease;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StWaitRelease;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      fire_q   <= '0;
      busy_q   <= 1'b0;
      shot_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      fire_q   <= fire_d;
      busy_q   <= (cnt_d != '0);
      shot_q   <= shot_d;
    end
  end

  assign fire          = fire_q;
  assign cooldown_busy = busy_q;
  assign shot_count    = shot_q;

endmodule
